// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: frame layout, FSM states
// and the parity/frame builders.
package uart_pkg;

    localparam int FRAME_W = 11;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic [FRAME_W-1:0] IDLE_FRAME = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        SEND  = 2'd3
    } sched_state_t;

    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    // Bit 0 is the start bit, data LSB sits at bit 1, stop bit at the top.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] data, input logic odd);
        return {STOP_BIT, calc_parity(data, odd), data, START_BIT};
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Two-requester valid/ready byte interface feeding the UART transmit scheduler.
interface uart_tx_scheduler_if;

    logic [7:0] req0_data;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req1_data;
    logic       req1_valid;
    logic       req1_ready;

    modport master (
        output req0_data, req0_valid, req1_data, req1_valid,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_data, req0_valid, req1_data, req1_valid,
        output req0_ready, req1_ready
    );

endinterface

// File: rtl/uart_tick_sync.sv
// Brings the asynchronous baud tick into the clk domain and emits a one-clk
// pulse on each rising edge.
module uart_tick_sync (
    input  logic clk,
    input  logic reset,
    input  logic tick_async,
    output logic tick_pulse
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Two-flop synchronizer followed by a delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= tick_async;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign tick_pulse = sync_r & ~prev_r;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that accepts bytes from two requesters, builds an
// 11-bit UART frame, pulses Tx_WR and holds off until the frame's ticks elapse.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned ODD_PARITY  = 0,
    parameter int unsigned FRAME_TICKS = 12
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_scheduler_if.slave req,
    input  logic               Tx_sample_ENABLE,
    output logic [FRAME_W-1:0] finalBitSequence,
    output logic               Tx_WR,
    output logic               grant_id,
    output logic               sched_busy
);

    localparam logic       ODD_SEL   = (ODD_PARITY != 0);
    localparam logic [3:0] LAST_TICK = 4'(FRAME_TICKS - 1);

    sched_state_t       state_r;
    sched_state_t       state_s;
    logic               last_grant_r;
    logic               grant_id_r;
    logic               tx_wr_r;
    logic               busy_r;
    logic [FRAME_W-1:0] frame_r;
    logic [3:0]         tick_cnt_r;
    logic               tick_pulse_s;
    logic               ready0_s;
    logic               ready1_s;
    logic               sel_s;
    logic               accept_s;
    logic [7:0]         sel_data_s;

    uart_tick_sync u_tick_sync (
        .clk        (clk),
        .reset      (reset),
        .tick_async (Tx_sample_ENABLE),
        .tick_pulse (tick_pulse_s)
    );

    // Round-robin arbitration; ready is gated by reset so nothing is offered while held.
    always_comb begin
        ready0_s = 1'b0;
        ready1_s = 1'b0;
        sel_s    = 1'b0;
        if ((state_r == IDLE) && reset) begin
            if (req.req0_valid && req.req1_valid) begin
                sel_s    = ~last_grant_r;
                ready0_s = last_grant_r;
                ready1_s = ~last_grant_r;
            end else if (req.req0_valid) begin
                sel_s    = 1'b0;
                ready0_s = 1'b1;
            end else if (req.req1_valid) begin
                sel_s    = 1'b1;
                ready1_s = 1'b1;
            end else begin
                sel_s = 1'b0;
            end
        end else begin
            sel_s = 1'b0;
        end
    end

    assign accept_s       = ready0_s | ready1_s;
    assign sel_data_s     = sel_s ? req.req1_data : req.req0_data;
    assign req.req0_ready = ready0_s;
    assign req.req1_ready = ready1_s;

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = LOAD;
                else          state_s = IDLE;
            end
            LOAD:  state_s = WRITE;
            WRITE: state_s = SEND;
            SEND: begin
                if (tick_pulse_s && (tick_cnt_r == LAST_TICK)) state_s = IDLE;
                else                                           state_s = SEND;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register plus registered strobe and busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            tx_wr_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            tx_wr_r <= (state_s == WRITE);
            busy_r  <= (state_s != IDLE);
        end
    end

    // Ticks only count in SEND; clearing through WRITE discards any early edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_r <= 4'd0;
        end else if (state_r == WRITE) begin
            tick_cnt_r <= 4'd0;
        end else if ((state_r == SEND) && tick_pulse_s) begin
            tick_cnt_r <= tick_cnt_r + 4'd1;
        end else begin
            tick_cnt_r <= tick_cnt_r;
        end
    end

    // Frame and grant are captured only at acceptance and held for the frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_r      <= IDLE_FRAME;
            grant_id_r   <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            frame_r      <= build_frame(sel_data_s, ODD_SEL);
            grant_id_r   <= sel_s;
            last_grant_r <= sel_s;
        end else begin
            frame_r      <= frame_r;
            grant_id_r   <= grant_id_r;
            last_grant_r <= last_grant_r;
        end
    end

    assign finalBitSequence = frame_r;
    assign Tx_WR            = tx_wr_r;
    assign grant_id         = grant_id_r;
    assign sched_busy       = busy_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: expected frames are queued as requests
// are driven and compared whenever Tx_WR fires.
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [10:0] frame, frame_odd;
    logic        wr, wr_odd, gid, gid_odd, busy, busy_odd;

    int          checks   = 0;
    int          failures = 0;
    int          wr_seen  = 0;
    logic [11:0] sb_q[$];
    logic [11:0] mon_exp;
    int          wr_before;

    uart_tx_scheduler_if bus();
    uart_tx_scheduler_if bus_odd();

    uart_tx_scheduler #(.ODD_PARITY(0), .FRAME_TICKS(12)) dut (
        .clk              (clk),
        .reset            (reset),
        .req              (bus.slave),
        .Tx_sample_ENABLE (tick),
        .finalBitSequence (frame),
        .Tx_WR            (wr),
        .grant_id         (gid),
        .sched_busy       (busy)
    );

    uart_tx_scheduler #(.ODD_PARITY(1), .FRAME_TICKS(12)) dut_odd (
        .clk              (clk),
        .reset            (reset),
        .req              (bus_odd.slave),
        .Tx_sample_ENABLE (tick),
        .finalBitSequence (frame_odd),
        .Tx_WR            (wr_odd),
        .grant_id         (gid_odd),
        .sched_busy       (busy_odd)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] exp_frame(input logic [7:0] d, input bit odd);
        logic p;
        p = ^d;
        if (odd) p = ~p;
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every Tx_WR cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        if (wr === 1'b1) begin
            wr_seen++;
            if (sb_q.size() == 0) begin
                check_eq("unexpected_wr", 16'(wr), 16'd0);
            end else begin
                mon_exp = sb_q.pop_front();
                check_eq("frame", 16'(frame), 16'(mon_exp[10:0]));
                check_eq("grant", 16'(gid), 16'(mon_exp[11]));
            end
        end
    end

    task automatic tick_pulse();
        tick = 1'b1;
        repeat (3) @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_req(input bit id, input logic [7:0] d, input bit with_tick);
        if (id) begin
            bus.req1_data  = d;
            bus.req1_valid = 1'b1;
        end else begin
            bus.req0_data  = d;
            bus.req0_valid = 1'b1;
        end
        if (with_tick) tick = 1'b1;
        sb_q.push_back({id, exp_frame(d, 1'b0)});
        #1;
        check_eq("ready_sel", 16'(id ? bus.req1_ready : bus.req0_ready), 16'd1);
        check_eq("ready_other", 16'(id ? bus.req0_ready : bus.req1_ready), 16'd0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    // Called at the LOAD-cycle negedge: Tx_WR must appear exactly in the next cycle.
    task automatic check_wr_timing();
        check_eq("wr_load", 16'(wr), 16'd0);
        check_eq("busy_load", 16'(busy), 16'd1);
        @(negedge clk);
        check_eq("wr_write", 16'(wr), 16'd1);
        @(negedge clk);
        check_eq("wr_send", 16'(wr), 16'd0);
        check_eq("busy_send", 16'(busy), 16'd1);
    endtask

    task automatic finish_frame();
        repeat (11) tick_pulse();
        check_eq("busy_after_11", 16'(busy), 16'd1);
        tick_pulse();
        check_eq("busy_after_12", 16'(busy), 16'd0);
    endtask

    task automatic wait_wr(input int target);
        int n;
        n = 0;
        while ((wr_seen < target) && (n < 40)) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("wr_arrive", 16'(wr_seen >= target), 16'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        tick  = 1'b0;
        bus.req0_data = 8'h00; bus.req0_valid = 1'b0;
        bus.req1_data = 8'h00; bus.req1_valid = 1'b0;
        bus_odd.req0_data = 8'h00; bus_odd.req0_valid = 1'b0;
        bus_odd.req1_data = 8'h00; bus_odd.req1_valid = 1'b0;

        // Reset state, including ready held low while a requester is valid.
        repeat (2) @(negedge clk);
        bus.req0_valid = 1'b1;
        #1;
        check_eq("rst_ready0", 16'(bus.req0_ready), 16'd0);
        check_eq("rst_frame", 16'(frame), 16'h7FF);
        check_eq("rst_wr", 16'(wr), 16'd0);
        check_eq("rst_grant", 16'(gid), 16'd0);
        check_eq("rst_busy", 16'(busy), 16'd0);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Odd parity instance, data 0x01.
        bus_odd.req0_data  = 8'h01;
        bus_odd.req0_valid = 1'b1;
        @(negedge clk);
        bus_odd.req0_valid = 1'b0;
        check_eq("odd_bit9", 16'(frame_odd[9]), 16'd0);
        check_eq("odd_bit0", 16'(frame_odd[0]), 16'd0);
        check_eq("odd_bit10", 16'(frame_odd[10]), 16'd1);
        check_eq("odd_frame", 16'(frame_odd), 16'(exp_frame(8'h01, 1'b1)));

        // Single request 0xA5 with even parity.
        send_req(1'b0, 8'hA5, 1'b0);
        check_eq("a5_frame", 16'(frame), 16'(11'b10101001010));
        check_wr_timing();
        finish_frame();

        // Tick edge landing before SEND must not be counted.
        send_req(1'b0, 8'h96, 1'b1);
        check_wr_timing();
        tick = 1'b0;
        repeat (3) @(negedge clk);
        finish_frame();

        // Data changes after acceptance must not reach the frame.
        send_req(1'b1, 8'h3C, 1'b0);
        bus.req1_data = 8'hFF;
        check_wr_timing();
        finish_frame();
        check_eq("hold_frame", 16'(frame), 16'(exp_frame(8'h3C, 1'b0)));

        // Reset in the middle of SEND, then a fresh frame.
        send_req(1'b0, 8'hC3, 1'b0);
        check_wr_timing();
        repeat (5) tick_pulse();
        reset = 1'b0;
        #1;
        check_eq("midrst_frame", 16'(frame), 16'h7FF);
        check_eq("midrst_wr", 16'(wr), 16'd0);
        check_eq("midrst_busy", 16'(busy), 16'd0);
        check_eq("midrst_grant", 16'(gid), 16'd0);
        wr_before = wr_seen;
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("no_wr_after_rst", 16'(wr_seen), 16'(wr_before));
        send_req(1'b1, 8'h5A, 1'b0);
        check_wr_timing();
        finish_frame();

        // Contention from a fresh reset: requester 0 first, then strict alternation.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus.req0_data  = 8'h11;
        bus.req1_data  = 8'h22;
        sb_q.push_back({1'b0, exp_frame(8'h11, 1'b0)});
        sb_q.push_back({1'b1, exp_frame(8'h22, 1'b0)});
        sb_q.push_back({1'b0, exp_frame(8'h11, 1'b0)});
        sb_q.push_back({1'b1, exp_frame(8'h22, 1'b0)});
        wr_before = wr_seen;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_wr(wr_before + f + 1);
            repeat (11) tick_pulse();
            if (f == 3) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            tick_pulse();
        end
        repeat (10) @(negedge clk);
        check_eq("sb_drained", 16'(sb_q.size()), 16'd0);
        check_eq("contend_idle", 16'(busy), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter ODD_PARITY, default 0, meaning: 0 gives even parity, 1 gives odd parity in frame bit 9.
REQ-002 Parameter FRAME_TICKS, default 12, meaning: detected sample ticks counted per frame after Tx_WR (11 bits plus 1 settling tick).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock; all state on its rising edge.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 req0_data  in  8  requester 0 byte.
REQ-007 req0_valid  in  1  requester 0 has a byte.
REQ-008 req0_ready  out  1  requester 0 byte accepted when valid&ready.
REQ-009 req1_data, req1_valid, req1_ready  in/in/out  8/1/1  same as requester 0, for requester 1.
REQ-010 Tx_sample_ENABLE  in  1  per-bit baud tick, asynchronous to clk.
REQ-011 finalBitSequence  out  11  frame to transmitter.
REQ-012 Tx_WR  out  1  one-clk start pulse to transmitter.
REQ-013 grant_id  out  1  requester owning current/last frame.
REQ-014 sched_busy  out  1  high from acceptance until frame end.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, WRITE, SEND, with transitions IDLE->LOAD (accept), LOAD->WRITE (one clk), WRITE->SEND (one clk), and SEND->IDLE (tick count reaches FRAME_TICKS).
REQ-016 In IDLE, the block SHALL assert ready to exactly one valid requester, combinationally from valid and the last grant; ready SHALL be low in all other states.
REQ-017 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; after reset, requester 0 wins a tie.
REQ-018 A lone valid requester SHALL be granted regardless of history.
REQ-019 On acceptance, the frame SHALL be {stop=1, parity, data[7:0], start=0} with bit 0 = start and data LSB at bit 1.
REQ-020 Parity SHALL be the XOR of data bits, inverted when ODD_PARITY=1.
REQ-021 finalBitSequence SHALL change only on the IDLE->LOAD edge and SHALL be stable for at least 1 clk before the Tx_WR pulse.
REQ-022 Tx_WR SHALL be high for exactly the single WRITE cycle; acceptance-to-Tx_WR latency is 2 clk.
REQ-023 Tx_sample_ENABLE SHALL pass through a 2-flop synchronizer and rising-edge detector.
REQ-024 Only edges detected in SEND SHALL increment the 4-bit tick counter; edges detected in LOAD/WRITE are ignored.
REQ-025 The counter SHALL clear on entry to SEND.
REQ-026 The FSM SHALL leave SEND on the cycle the count reaches FRAME_TICKS.
REQ-027 A new acceptance SHALL be possible the cycle after returning to IDLE, giving back-to-back frames.
REQ-028 A requester dropping valid while not yet accepted SHALL lose no state, and no frame is produced.
REQ-029 Data SHALL be captured at acceptance; later changes on req*_data do not affect the frame in flight.
REQ-030 sched_busy SHALL be high in LOAD, WRITE and SEND.

Reset
REQ-031 On reset assertion, regardless of state: FSM=IDLE, finalBitSequence=11'h7FF, Tx_WR=0, ready outputs=0, grant_id=0, tick counter=0, synchronizer flops=0, last-grant=1 (so requester 0 wins the first tie).
REQ-032 Reset assertion mid-frame SHALL abort the frame without emitting a Tx_WR pulse; after release the block SHALL start in IDLE.

Structure
REQ-033 A shared package uart_pkg SHALL hold the FSM state type, FRAME_W=11, START_BIT=0, STOP_BIT=1, IDLE_FRAME=11'h7FF.
REQ-034 One sub-module, uart_tick_sync (synchronizer plus edge detector, 1-clk pulse output), SHALL be instantiated; all other logic is in uart_tx_scheduler.

Verification
REQ-035 Single request: req0 data 8'hA5, even parity -> finalBitSequence=11'b1_0_10100101_0, Tx_WR 2 clk after accept, sched_busy low after 12 ticks.
REQ-036 Odd parity: ODD_PARITY=1, data 8'h01 -> bit 9=0, bit 0=0, bit 10=1.
REQ-037 Contention: both valid continuously with data 8'h11/8'h22 -> frames alternate 11,22,11,22, requester 0 first.
REQ-038 Tick during LOAD/WRITE: force a Tx_sample_ENABLE edge in the Tx_WR cycle -> not counted, still exactly 12 counted ticks in SEND.
REQ-039 Reset mid-SEND, after 5 ticks -> outputs at reset values immediately, no further Tx_WR pulse; a fresh request after release produces a normal frame.
REQ-040 Data change after accept: req1_data changes from 8'h3C to 8'hFF one clk after acceptance -> the frame still carries 8'h3C.
